// File: rtl/uart_word_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_word_serializer_if
// Bundles the word-side handshake and the byte-side transmitter handshake of
// uart_word_serializer, plus its status outputs.
//
// Signals:
//   in_valid, in_data, in_ready   word push handshake (in_ready == !full)
//   flush                         discard all queued words
//   msb_first                     byte order for the next word loaded
//   tx_start, tx_byte             one-cycle byte start pulse and held byte
//   tx_done_tick                  transmitter finished the current byte
//   word_done, all_done           completion pulses
//   count, empty, full, busy      FIFO occupancy and FSM status
//
// Modports:
//   master  drives the inputs of the serializer (producer + transmitter side)
//   slave   the serializer itself
// -----------------------------------------------------------------------------
interface uart_word_serializer_if #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 64,
    parameter int CNT_W      = $clog2(DEPTH) + 1
);
    logic                    in_valid;
    logic [8*WORD_BYTES-1:0] in_data;
    logic                    in_ready;
    logic                    flush;
    logic                    msb_first;
    logic                    tx_start;
    logic [7:0]              tx_byte;
    logic                    tx_done_tick;
    logic                    word_done;
    logic                    all_done;
    logic [CNT_W-1:0]        count;
    logic                    empty;
    logic                    full;
    logic                    busy;

    modport master (
        output in_valid, in_data, flush, msb_first, tx_done_tick,
        input  in_ready, tx_start, tx_byte, word_done, all_done,
               count, empty, full, busy
    );

    modport slave (
        input  in_valid, in_data, flush, msb_first, tx_done_tick,
        output in_ready, tx_start, tx_byte, word_done, all_done,
               count, empty, full, busy
    );
endinterface

// File: rtl/uart_word_serializer.sv
// -----------------------------------------------------------------------------
// uart_word_serializer
// Word-to-byte transmit buffer between the debug/instruction-load logic and
// the UART transmitter. Words are queued in a circular FIFO, loaded one at a
// time into a shift register and sent as bytes, one tx_start pulse per byte,
// paced by tx_done_tick from the transmitter.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    uart_word_serializer_if.slave (push handshake, flush, byte order,
//          byte start/done handshake, completion pulses, occupancy status)
//
// Optional feature (macro UART_SER_CHECKSUM_EN): each word is followed by one
// extra byte holding the XOR of its data bytes; word_done then follows the
// checksum byte's tx_done_tick.
// -----------------------------------------------------------------------------
module uart_word_serializer #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 64,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_word_serializer_if.slave        bus
);
    localparam int DW = 8 * WORD_BYTES;
    localparam int AW = $clog2(DEPTH);
`ifdef UART_SER_CHECKSUM_EN
    localparam int FRAME_BYTES = WORD_BYTES + 1;
`else
    localparam int FRAME_BYTES = WORD_BYTES;
`endif
    localparam int BC_W = $clog2(FRAME_BYTES + 1);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t            state_q;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DW-1:0]     word_q;
    logic              msb_q;
    logic [BC_W-1:0]   byte_cnt_q;
    logic              tx_start_q, word_done_q, all_done_q;
    logic [7:0]        tx_byte_q;

    logic              full, empty, push, pop, last_tick;
    logic [BC_W-1:0]   byte_sel;
    logic [7:0]        data_byte, frame_byte;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO rejects the push even if a pop frees a slot this cycle.
    assign push = bus.in_valid && !full && !bus.flush;

    assign last_tick = (state_q == S_WAIT) && bus.tx_done_tick && (byte_cnt_q == LAST_IDX);

    // Flush wins over a pop: queued words are discarded, not loaded.
    assign pop = !empty && !bus.flush && ((state_q == S_IDLE) || last_tick);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset so it can map onto RAM; only the
    // pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (bus.flush) begin
                rd_ptr_q <= wr_ptr_q;
                count_q  <= '0;
            end else begin
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
            end
        end
    end

    // Byte position within the word, honouring the order latched at load.
    assign byte_sel = msb_q ? (BC_W'(WORD_BYTES - 1) - byte_cnt_q) : byte_cnt_q;

    always_comb begin
        // NOTE: default assignment first so no path leaves data_byte unassigned
        // and no latch is inferred.
        data_byte = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_sel == BC_W'(i)) data_byte = word_q[i*8 +: 8];
        end
    end

`ifdef UART_SER_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < WORD_BYTES; i++) csum = csum ^ word_q[i*8 +: 8];
    end

    // The extra frame slot after the data bytes carries the checksum.
    assign frame_byte = (byte_cnt_q == BC_W'(WORD_BYTES)) ? csum : data_byte;
`else
    assign frame_byte = data_byte;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            msb_q       <= 1'b0;
            byte_cnt_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= '0;
            word_done_q <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
            all_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        word_q     <= mem_q[rd_ptr_q];
                        msb_q      <= bus.msb_first;
                        byte_cnt_q <= '0;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: state_q <= S_SEND;
                S_SEND: begin
                    tx_byte_q  <= frame_byte;
                    tx_start_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tx_done_tick) begin
                        if (byte_cnt_q != LAST_IDX) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= S_SEND;
                        end else begin
                            word_done_q <= 1'b1;
                            all_done_q  <= (empty || bus.flush) && !push;
                            if (pop) begin
                                word_q     <= mem_q[rd_ptr_q];
                                msb_q      <= bus.msb_first;
                                byte_cnt_q <= '0;
                                state_q    <= S_LOAD;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !full;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.word_done = word_done_q;
    assign bus.all_done  = all_done_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
